srl16_fifo_ctrl: RTL and testbench

- Occupancy and address controller that turns one or more parallel X_SRLC16E cells into a first-word-fall-through FIFO, up to 16 entries deep.
- Drives the shared SRL CE and A3..A0 pins.
- Tracks fill level and exposes FULL, EMPTY and ALMOST_FULL handshake flags to the writer and reader.
- Write data goes straight to the SRL D pins. Read data is the SRL Q outputs, valid whenever EMPTY=0.

---
 rtl/srl16_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_srl16_fifo_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/srl16_fifo_ctrl.sv
// Occupancy/address controller that turns parallel SRLC16E cells into a FWFT FIFO.
// Optional sticky OVERFLOW/UNDERFLOW flags with ERR_CLR when SRL16_FIFO_CTRL_ERR_EN is defined.
module srl16_fifo_ctrl #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 14
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR_EN,
  input  logic       RD_EN,
`ifdef SRL16_FIFO_CTRL_ERR_EN
  input  logic       ERR_CLR,
  output logic       OVERFLOW,
  output logic       UNDERFLOW,
`endif
  output logic       SRL_CE,
  output logic [3:0] SRL_A,
  output logic       FULL,
  output logic       EMPTY,
  output logic       ALMOST_FULL,
  output logic [4:0] COUNT,
  output logic [1:0] DBG_STATE
);

  // Handshake: a write is accepted when WR_EN=1 and FULL=0 at a rising edge;
  // a read is accepted when RD_EN=1 and EMPTY=0. Rejected requests have no effect.

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MID   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  localparam logic [4:0] DEPTH_C  = 5'(DEPTH);
  localparam logic [4:0] THRESH_C = 5'(AFULL_THRESH);

  state_e     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [3:0] addr_q, addr_d;
  logic       afull_q, afull_d;
  logic       push, pop;

  assign FULL  = (state_q == S_FULL);
  assign EMPTY = (state_q == S_EMPTY);
  assign push  = WR_EN & ~FULL;
  assign pop   = RD_EN & ~EMPTY;

  assign SRL_CE      = push;
  assign SRL_A       = addr_q;
  assign COUNT       = count_q;
  assign ALMOST_FULL = afull_q;
  assign DBG_STATE   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_MID;
      S_MID: begin
        if (push && !pop && count_q == DEPTH_C - 5'd1)
          state_d = S_FULL;
        else if (pop && !push && count_q == 5'd1)
          state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_MID;
      default: state_d = S_EMPTY;
    endcase
  end

  // The oldest word sits at position COUNT-1, so the read address tracks occupancy.
  always_comb begin
    count_d = count_q + {4'd0, push} - {4'd0, pop};
    addr_d  = addr_q;
    if (push && !pop)
      addr_d = count_q[3:0];
    else if (pop && !push)
      addr_d = (count_d == 5'd0) ? 4'd0 : 4'(count_q - 5'd2);
    afull_d = (count_d >= THRESH_C);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_EMPTY;
      count_q <= 5'd0;
      addr_q  <= 4'd0;
      afull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      afull_q <= afull_d;
    end
  end

`ifdef SRL16_FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error event in the same cycle as ERR_CLR keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ERR_CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (WR_EN && FULL)  ovf_d = 1'b1;
    if (RD_EN && EMPTY) unf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
`endif

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Directed bench for srl16_fifo_ctrl with a behavioural 16x8 SRL and an expected-word queue.
// Covers the SRL16_FIFO_CTRL_ERR_EN flags when that macro is defined.
module tb_srl16_fifo_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       WR_EN;
  logic       RD_EN;
  logic       SRL_CE;
  logic [3:0] SRL_A;
  logic       FULL;
  logic       EMPTY;
  logic       ALMOST_FULL;
  logic [4:0] COUNT;
  logic [1:0] DBG_STATE;
`ifdef SRL16_FIFO_CTRL_ERR_EN
  logic       ERR_CLR;
  logic       OVERFLOW;
  logic       UNDERFLOW;
`endif

  logic [7:0] wr_data;
  logic [7:0] srl [16];
  logic [7:0] q;

  logic [7:0] exp_q[$];
  int         exp_count;
  logic       exp_ovf;
  logic       exp_unf;
  logic       err_clr_v;

  int n_checks;
  int n_pass;

  srl16_fifo_ctrl #(.DEPTH(16), .AFULL_THRESH(14)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .WR_EN       (WR_EN),
    .RD_EN       (RD_EN),
`ifdef SRL16_FIFO_CTRL_ERR_EN
    .ERR_CLR     (ERR_CLR),
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW),
`endif
    .SRL_CE      (SRL_CE),
    .SRL_A       (SRL_A),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .ALMOST_FULL (ALMOST_FULL),
    .COUNT       (COUNT),
    .DBG_STATE   (DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // behavioural SRLC16E cells (8 in parallel), no reset
  always @(posedge CLK) begin
    if (SRL_CE) begin
      for (int i = 15; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= wr_data;
    end
  end
  assign q = srl[SRL_A];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_outputs();
    chk("count", {3'd0, COUNT}, 8'(exp_count));
    chk("empty", {7'd0, EMPTY}, {7'd0, exp_count == 0});
    chk("full", {7'd0, FULL}, {7'd0, exp_count == 16});
    chk("afull", {7'd0, ALMOST_FULL}, {7'd0, exp_count >= 14});
    chk("srl_a", {4'd0, SRL_A}, (exp_count == 0) ? 8'd0 : 8'(exp_count - 1));
    if (exp_count != 0) chk("q_head", q, exp_q[0]);
`ifdef SRL16_FIFO_CTRL_ERR_EN
    chk("overflow", {7'd0, OVERFLOW}, {7'd0, exp_ovf});
    chk("underflow", {7'd0, UNDERFLOW}, {7'd0, exp_unf});
`endif
  endtask

  // driver: called just after a falling edge; drives one cycle and checks the result
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
    logic push, pop;
    WR_EN   = wr;
    RD_EN   = rd;
    wr_data = d;
`ifdef SRL16_FIFO_CTRL_ERR_EN
    ERR_CLR = err_clr_v;
`endif
    #1;
    push = wr && (exp_count != 16);
    pop  = rd && (exp_count != 0);
    chk("srl_ce", {7'd0, SRL_CE}, {7'd0, push});
    if (pop) begin
      chk("q_pop", q, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (push) exp_q.push_back(d);
    if (wr && exp_count == 16) exp_ovf = 1'b1;
    else if (err_clr_v) exp_ovf = 1'b0;
    if (rd && exp_count == 0) exp_unf = 1'b1;
    else if (err_clr_v) exp_unf = 1'b0;
    exp_count = exp_count + int'(push) - int'(pop);
    @(posedge CLK);
    @(negedge CLK);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    chk_outputs();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_count = 0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    err_clr_v = 1'b0;
    RST_N     = 1'b0;
    WR_EN     = 1'b0;
    RD_EN     = 1'b0;
    wr_data   = 8'h00;
`ifdef SRL16_FIFO_CTRL_ERR_EN
    ERR_CLR   = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk_outputs();
    RST_N = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00);

    // three writes, one pop, drain, then a read on empty
    cyc(1'b1, 1'b0, 8'hA1);
    cyc(1'b1, 1'b0, 8'hB2);
    cyc(1'b1, 1'b0, 8'hC3);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
`ifdef SRL16_FIFO_CTRL_ERR_EN
    chk("unf_set", {7'd0, UNDERFLOW}, 8'd1);
    cyc(1'b0, 1'b0, 8'h00);
    err_clr_v = 1'b1;
    cyc(1'b0, 1'b1, 8'h00);
    chk("unf_set_wins", {7'd0, UNDERFLOW}, 8'd1);
    cyc(1'b0, 1'b0, 8'h00);
    err_clr_v = 1'b0;
`endif

    // fill past full, then drain
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(i));
`ifdef SRL16_FIFO_CTRL_ERR_EN
    chk("ovf_set", {7'd0, OVERFLOW}, 8'd1);
    err_clr_v = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    err_clr_v = 1'b0;
`endif
    // simultaneous request while full is a pop only
    cyc(1'b1, 1'b1, 8'hEE);
    cyc(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

    // simultaneous request while empty is a push only
    cyc(1'b1, 1'b1, 8'h77);
    cyc(1'b0, 1'b1, 8'h00);

    // steady state at COUNT=5 with push and pop together
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));

    // asynchronous reset mid-burst
    while (exp_count < 7) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    while (exp_count > 7) cyc(1'b0, 1'b1, 8'h00);
    WR_EN = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    exp_count = 0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk_outputs();
    WR_EN = 1'b0;
    @(negedge CLK);
    chk_outputs();
    RST_N = 1'b1;
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b0, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
